// File: rtl/bpred_pkg.sv
// ============================================================================
// Module  : bpred_pkg
// Purpose : Shared encodings and helpers for the branch predictor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package bpred_pkg;

  localparam logic [1:0] KIND_BR   = 2'd0;
  localparam logic [1:0] KIND_JAL  = 2'd1;
  localparam logic [1:0] KIND_JALR = 2'd2;
  localparam logic [1:0] KIND_RSVD = 2'd3;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bpred_ras.sv
// ============================================================================
// Module  : bpred_ras
// Purpose : Circular return-address stack; a push when full drops the oldest.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bpred_ras
  import bpred_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            valid
);

  localparam int PTR_W = clog2(DEPTH);

  logic [XLEN-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_pop_ok;
  logic [PTR_W-1:0] w_ptr_base;
  logic [PTR_W:0]   w_count_base;
  logic [PTR_W-1:0] w_top_idx;

  // Pop is applied first so a simultaneous push replaces the top.
  always_comb begin
    w_pop_ok     = pop && (r_count != '0);
    w_ptr_base   = w_pop_ok ? (r_ptr - 1'b1) : r_ptr;
    w_count_base = w_pop_ok ? (r_count - 1'b1) : r_count;
    w_top_idx    = r_ptr - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push) begin
      r_mem[w_ptr_base] <= push_data;
      r_ptr             <= w_ptr_base + 1'b1;
      r_count           <= (w_count_base == (PTR_W+1)'(DEPTH)) ? w_count_base
                                                               : w_count_base + 1'b1;
    end else begin
      r_ptr   <= w_ptr_base;
      r_count <= w_count_base;
    end
  end

  assign top   = r_mem[w_top_idx];
  assign valid = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module  : branch_predictor
// Purpose : Direct-mapped BTB with 2-bit counters; optional RAS (BPRED_RAS_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_predictor
  import bpred_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int RAS_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [1:0]      upd_kind,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_call,
  input  logic            upd_ret
);

  localparam int IDX_W = clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [BTB_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        r_target [BTB_ENTRIES];
  logic [1:0]             r_kind   [BTB_ENTRIES];
  logic [1:0]             r_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] w_pred_idx;
  logic [TAG_W-1:0] w_pred_tag;
  logic [1:0]       w_pred_kind;
  logic [XLEN-1:0]  w_pc_plus4;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_en;
  logic             w_upd_hit;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_next;
  logic             w_ras_valid;
  logic [XLEN-1:0]  w_ras_top;
  logic             w_unused_pc;

  assign w_pred_idx  = pred_pc[IDX_W+1:2];
  assign w_pred_tag  = pred_pc[XLEN-1:IDX_W+2];
  assign w_pred_kind = r_kind[w_pred_idx];
  assign w_pc_plus4  = pred_pc + XLEN'(4);

  assign pred_hit   = r_valid[w_pred_idx] && (r_tag[w_pred_idx] == w_pred_tag);
  assign pred_taken = pred_hit && ((w_pred_kind != KIND_BR) || r_ctr[w_pred_idx][1]);

  always_comb begin
    pred_target = w_pc_plus4;
    if (pred_taken) begin
      if ((w_pred_kind == KIND_JALR) && w_ras_valid) pred_target = w_ras_top;
      else                                           pred_target = r_target[w_pred_idx];
    end
  end

  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[XLEN-1:IDX_W+2];
  assign w_upd_en  = upd_valid && (upd_kind != KIND_RSVD);
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_ctr_cur = r_ctr[w_upd_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (upd_taken && (w_ctr_cur != CTR_ST))        w_ctr_next = w_ctr_cur + 2'd1;
    else if (!upd_taken && (w_ctr_cur != CTR_SNT)) w_ctr_next = w_ctr_cur - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_kind[i]   <= KIND_BR;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (w_upd_en) begin
      if (w_upd_hit) begin
        if (upd_kind == KIND_BR) begin
          r_ctr[w_upd_idx] <= w_ctr_next;
          if (upd_taken) r_target[w_upd_idx] <= upd_target;
        end else begin
          r_target[w_upd_idx] <= upd_target;
          r_kind[w_upd_idx]   <= upd_kind;
        end
      end else if (upd_taken) begin
        // Not-taken misses never allocate, keeping cold branches out of the table.
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_kind[w_upd_idx]   <= upd_kind;
        r_ctr[w_upd_idx]    <= (upd_kind == KIND_BR) ? CTR_WT : CTR_ST;
      end
    end
  end

  assign w_unused_pc = &{1'b0, pred_pc[1:0], upd_pc[1:0]};

`ifdef BPRED_RAS_EN
  bpred_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_upd_en && upd_call),
    .pop       (w_upd_en && upd_ret),
    .push_data (upd_pc + XLEN'(4)),
    .top       (w_ras_top),
    .valid     (w_ras_valid)
  );
`else
  logic w_unused_ras;
  assign w_ras_valid  = 1'b0;
  assign w_ras_top    = '0;
  assign w_unused_ras = &{1'b0, upd_call, upd_ret, (RAS_DEPTH > 0)};
`endif

endmodule

`default_nettype wire
